pack_u: RTL

//  Inverse of the uniform-sample unpacker: accepts coefficients reduced mod q (24-bit q1 or 49-bit q),

---
 rtl/pack_u_if.sv | 28 ++
 rtl/pack_u.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pack_u_if.sv
// Handshake bundle for the coefficient packer: control/config, input
// coefficient stream, packed output word stream and status flags.
interface pack_u_if;
  logic        start;
  logic [5:0]  u;
  logic        u_mod;
  logic [48:0] coef;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [47:0] dout;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic        coef_err;

  modport master (
    output start, u, u_mod, coef, in_valid, flush, out_ready,
    input  in_ready, dout, out_valid, busy, done, cfg_err, coef_err
  );

  modport slave (
    input  start, u, u_mod, coef, in_valid, flush, out_ready,
    output in_ready, dout, out_valid, busy, done, cfg_err, coef_err
  );
endinterface

// File: rtl/pack_u.sv
// Coefficient packer: lifts coefficients mod q1/q to their centred signed
// value, keeps the low u bits and packs them LSB-first into a bit stream
// emitted as 48-bit words (first stream byte in dout[47:40]).
//
// state | meaning
// IDLE  | waiting for start; datapath held empty
// RUN   | accepting coefficients, emitting full words
// FLUSH | input closed; drain stage 1, pad to word boundary, emit rest
// DONE  | one cycle, done pulse visible, then back to IDLE
module pack_u (
  input logic      clk,
  input logic      rst,
  pack_u_if.slave  bus
);

  localparam logic [48:0] Q1 = 49'd16515073;
  localparam logic [48:0] Q  = 49'h1f41002f80001;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t      state;
  logic [5:0]  u_r;
  logic        mod_r;
  logic        done_r;
  logic        cfg_err_r;
  logic        coef_err_r;

  logic        s1_valid;
  logic [40:0] s1_field;
  logic [95:0] acc;
  logic [6:0]  fill;

  logic [48:0] m;
  logic [48:0] v;
  logic [48:0] half;
  logic [40:0] s_low;
  logic [40:0] mask;
  logic [40:0] field;
  logic        start_legal;
  logic [7:0]  fill_need;
  logic        in_ready_c;
  logic        in_fire;
  logic        out_valid_c;
  logic        out_fire;
  logic        drained;
  logic [6:0]  fill_rnd;
  logic [6:0]  fill_base;
  logic [6:0]  append_pos;
  logic [6:0]  fill_next;
  logic [95:0] acc_next;
  logic [47:0] dout_c;

  // Stage-1 lift: centre the coefficient and keep its low u bits. Only the
  // low 41 bits of the difference are ever used, so the subtraction is
  // done at that width (two's complement truncation gives the same bits).
  always_comb begin
    m     = mod_r ? Q : Q1;
    v     = mod_r ? bus.coef : {25'd0, bus.coef[23:0]};
    half  = (m - 49'd1) >> 1;
    s_low = (v > half) ? (v[40:0] - m[40:0]) : v[40:0];
    mask  = ~({41{1'b1}} << u_r);
    field = s_low & mask;
  end

  // Field-width legality of the pins sampled at start.
  always_comb begin
    start_legal = 1'b0;
    if (bus.u != 6'd0) begin
      start_legal = bus.u_mod ? (bus.u <= 6'd41) : (bus.u <= 6'd8);
    end
  end

  // Handshakes; in_ready looks at registers only so it never depends on
  // same-cycle downstream activity. Admitting only while fill + pending
  // field fits in 47 bits caps fill at 88.
  always_comb begin
    fill_need   = {1'b0, fill} + (s1_valid ? {2'b00, u_r} : 8'd0);
    in_ready_c  = (state == RUN) && (fill_need <= 8'd47);
    in_fire     = bus.in_valid && in_ready_c;
    out_valid_c = ((state == RUN) || (state == FLUSH)) && (fill >= 7'd48);
    out_fire    = out_valid_c && bus.out_ready;
  end

  // Accumulator update: once stage 1 is drained during FLUSH the fill is
  // rounded up to a word boundary (bits above fill are always zero); a
  // consume shifts the word out and any concurrent append lands 48 lower.
  always_comb begin
    drained = (state == FLUSH) && !s1_valid;
    if (fill == 7'd0) begin
      fill_rnd = 7'd0;
    end else if (fill <= 7'd48) begin
      fill_rnd = 7'd48;
    end else begin
      fill_rnd = 7'd96;
    end
    fill_base  = drained ? fill_rnd : fill;
    append_pos = fill_base - (out_fire ? 7'd48 : 7'd0);
    fill_next  = append_pos + (s1_valid ? {1'b0, u_r} : 7'd0);
    acc_next   = out_fire ? (acc >> 48) : acc;
    if (s1_valid) begin
      acc_next = acc_next | ({55'd0, s1_field} << append_pos);
    end
  end

  // Byte order: stream byte k (acc bits 8k+7..8k) goes to dout[47-8k -: 8].
  always_comb begin
    dout_c = '0;
    for (int k = 0; k < 6; k++) begin
      dout_c[47-8*k -: 8] = acc[8*k +: 8];
    end
  end

  // Control FSM with registered done and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      u_r        <= 6'd0;
      mod_r      <= 1'b0;
      done_r     <= 1'b0;
      cfg_err_r  <= 1'b0;
      coef_err_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            coef_err_r <= 1'b0;
            if (start_legal) begin
              cfg_err_r <= 1'b0;
              u_r       <= bus.u;
              mod_r     <= bus.u_mod;
              state     <= RUN;
            end else begin
              cfg_err_r <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.flush) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (!s1_valid && (fill_next == 7'd0)) begin
            state  <= DONE;
            done_r <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      if (in_fire && (v >= m)) begin
        coef_err_r <= 1'b1;
      end
    end
  end

  // Datapath registers; held empty outside a packet so a reset or a
  // finished packet never leaves stale bits behind.
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE)) begin
      s1_valid <= 1'b0;
      s1_field <= '0;
      acc      <= '0;
      fill     <= 7'd0;
    end else begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_field <= field;
      end
      acc  <= acc_next;
      fill <= fill_next;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.dout      = dout_c;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_r;
  assign bus.cfg_err   = cfg_err_r;
  assign bus.coef_err  = coef_err_r;

endmodule
